// File: rtl/robo_pkg.sv
// Shared definitions for the robot actuator: FSM states, heading codes and
// default step counts.
package robo_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GIRO   = 2'd1,
    AVANCO = 2'd2,
    FIM    = 2'd3
  } estado_t;

  localparam logic [1:0] HEAD_N = 2'd0;
  localparam logic [1:0] HEAD_E = 2'd1;
  localparam logic [1:0] HEAD_S = 2'd2;
  localparam logic [1:0] HEAD_W = 2'd3;

  localparam int STEPS_AVANCO_DEF = 8;
  localparam int STEPS_GIRO_DEF   = 4;

endpackage

// File: rtl/robo_passo_cnt.sv
// Step counter: cleared on state entry, counts motor cycles, flags the last one.
module robo_passo_cnt (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic [7:0] count,
  output logic       last
);

  logic [7:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= 8'd0;
    end else if (enable) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign count = r_count;
  assign last  = (r_count == (limit - 8'd1));

endmodule

// File: rtl/robo_atuador.sv
// Wall-follower actuator: executes turn / advance / turn-then-advance
// sequences and tracks heading and grid position; all outputs registered.
module robo_atuador
  import robo_pkg::*;
#(
  parameter int STEPS_AVANCO = STEPS_AVANCO_DEF,
  parameter int STEPS_GIRO   = STEPS_GIRO_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       avancar,
  input  logic       girar,
  output logic       motor_esq_en,
  output logic       motor_dir_en,
  output logic       motor_dir_rev,
  output logic [1:0] heading,
  output logic [3:0] pos_x,
  output logic [3:0] pos_y,
  output logic       busy,
  output logic       done
);

  estado_t    r_state, w_state_nxt;
  logic       r_pend,  w_pend_nxt;
  logic [1:0] r_heading, w_heading_nxt;
  logic [3:0] r_pos_x, w_pos_x_nxt;
  logic [3:0] r_pos_y, w_pos_y_nxt;
  logic       r_motor, r_rev, r_busy, r_done;

  logic [7:0] w_limit;
  logic [7:0] w_count;
  logic       w_last;
  logic       w_clear;
  logic       w_enable;

  assign w_limit  = (r_state == GIRO) ? 8'(STEPS_GIRO) : 8'(STEPS_AVANCO);
  assign w_enable = (r_state == GIRO) || (r_state == AVANCO);
  // Counter restarts at every state entry, including GIRO -> AVANCO.
  assign w_clear  = (w_state_nxt != r_state);

  robo_passo_cnt u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_clear),
    .enable (w_enable),
    .limit  (w_limit),
    .count  (w_count),
    .last   (w_last)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_pend_nxt    = r_pend;
    w_heading_nxt = r_heading;
    w_pos_x_nxt   = r_pos_x;
    w_pos_y_nxt   = r_pos_y;
    case (r_state)
      IDLE: begin
        if (girar) begin
          w_state_nxt = GIRO;
          w_pend_nxt  = avancar;
        end else if (avancar) begin
          w_state_nxt = AVANCO;
        end
      end
      GIRO: begin
        if (w_last) begin
          w_heading_nxt = r_heading + 2'd1;
          w_pend_nxt    = 1'b0;
          w_state_nxt   = r_pend ? AVANCO : FIM;
        end
      end
      AVANCO: begin
        if (w_last) begin
          w_state_nxt = FIM;
          case (r_heading)
            HEAD_N:  w_pos_y_nxt = r_pos_y + 4'd1;
            HEAD_E:  w_pos_x_nxt = r_pos_x + 4'd1;
            HEAD_S:  w_pos_y_nxt = r_pos_y - 4'd1;
            default: w_pos_x_nxt = r_pos_x - 4'd1;
          endcase
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pend    <= 1'b0;
      r_heading <= HEAD_N;
      r_pos_x   <= 4'd0;
      r_pos_y   <= 4'd0;
      r_motor   <= 1'b0;
      r_rev     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pend    <= w_pend_nxt;
      r_heading <= w_heading_nxt;
      r_pos_x   <= w_pos_x_nxt;
      r_pos_y   <= w_pos_y_nxt;
      r_motor   <= (w_state_nxt == GIRO) || (w_state_nxt == AVANCO);
      r_rev     <= (w_state_nxt == GIRO);
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= (w_state_nxt == FIM);
    end
  end

  assign motor_esq_en  = r_motor;
  assign motor_dir_en  = r_motor;
  assign motor_dir_rev = r_rev;
  assign heading       = r_heading;
  assign pos_x         = r_pos_x;
  assign pos_y         = r_pos_y;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_robo_atuador.sv
// Scoreboard bench for robo_atuador: stimulus queues expected sequence results,
// a monitor checks them at each done pulse.
module tb_robo_atuador;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       avancar = 1'b0;
  logic       girar = 1'b0;
  logic       motor_esq_en, motor_dir_en, motor_dir_rev;
  logic [1:0] heading;
  logic [3:0] pos_x, pos_y;
  logic       busy, done;

  typedef struct {
    int h; int x; int y; int bz; int mt; int rv;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int busy_cnt = 0, mot_cnt = 0, rev_cnt = 0;

  robo_atuador #(.STEPS_AVANCO(8), .STEPS_GIRO(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .avancar       (avancar),
    .girar         (girar),
    .motor_esq_en  (motor_esq_en),
    .motor_dir_en  (motor_dir_en),
    .motor_dir_rev (motor_dir_rev),
    .heading       (heading),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: accumulates per-sequence cycle counts and compares at done.
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt = 0; mot_cnt = 0; rev_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (motor_esq_en && motor_dir_en) mot_cnt++;
      if (motor_dir_rev) rev_cnt++;
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("heading", int'(heading), e.h);
          chk("pos_x", int'(pos_x), e.x);
          chk("pos_y", int'(pos_y), e.y);
          chk("busy_cycles", busy_cnt, e.bz);
          chk("motor_cycles", mot_cnt, e.mt);
          chk("rev_cycles", rev_cnt, e.rv);
        end
        busy_cnt = 0; mot_cnt = 0; rev_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; avancar = 1'b0; girar = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_motors"}, int'({motor_esq_en, motor_dir_en, motor_dir_rev}), 0);
    chk({tag, "_heading"}, int'(heading), 0);
    chk({tag, "_pos"}, int'({pos_x, pos_y}), 0);
    chk({tag, "_busy_done"}, int'({busy, done}), 0);
  endtask

  task automatic issue(input logic av, input logic gi, input exp_t e);
    @(negedge clock);
    avancar = av; girar = gi;
    q.push_back(e);
    @(negedge clock);
    avancar = 1'b0; girar = 1'b0;
    chk("busy_rise", int'(busy), 1);
    wait_idle();
  endtask

  function automatic exp_t mk(int h, int x, int y, int bz, int mt, int rv);
    exp_t e;
    e.h = h; e.x = x; e.y = y; e.bz = bz; e.mt = mt; e.rv = rv;
    return e;
  endfunction

  initial begin
    do_reset();
    chk_zero("reset");

    // Single advance from reset.
    issue(1'b1, 1'b0, mk(0, 0, 1, 9, 8, 0));

    // Four turns from reset.
    do_reset();
    issue(1'b0, 1'b1, mk(1, 0, 0, 5, 4, 4));
    issue(1'b0, 1'b1, mk(2, 0, 0, 5, 4, 4));
    issue(1'b0, 1'b1, mk(3, 0, 0, 5, 4, 4));
    issue(1'b0, 1'b1, mk(0, 0, 0, 5, 4, 4));

    // Combined command: turn then advance east.
    do_reset();
    issue(1'b1, 1'b1, mk(1, 1, 0, 13, 12, 4));

    // Wrap-around of x and y.
    do_reset();
    issue(1'b0, 1'b1, mk(1, 0, 0, 5, 4, 4));
    issue(1'b0, 1'b1, mk(2, 0, 0, 5, 4, 4));
    issue(1'b0, 1'b1, mk(3, 0, 0, 5, 4, 4));
    issue(1'b1, 1'b0, mk(3, 15, 0, 9, 8, 0));
    issue(1'b0, 1'b1, mk(0, 15, 0, 5, 4, 4));
    issue(1'b0, 1'b1, mk(1, 15, 0, 5, 4, 4));
    issue(1'b0, 1'b1, mk(2, 15, 0, 5, 4, 4));
    issue(1'b1, 1'b0, mk(2, 15, 15, 9, 8, 0));
    issue(1'b0, 1'b1, mk(3, 15, 15, 5, 4, 4));
    issue(1'b0, 1'b1, mk(0, 15, 15, 5, 4, 4));
    issue(1'b1, 1'b0, mk(0, 15, 0, 9, 8, 0));

    // Commands toggled while busy must be ignored.
    @(negedge clock);
    avancar = 1'b1; girar = 1'b0;
    q.push_back(mk(0, 15, 1, 9, 8, 0));
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      avancar = i[0]; girar = ~i[0];
    end
    @(negedge clock);
    avancar = 1'b0; girar = 1'b0;
    wait_idle();
    repeat (15) @(negedge clock);
    chk("idle_after_toggle", int'(busy), 0);

    // Reset during cycle 5 of an advance aborts without done.
    do_reset();
    @(negedge clock);
    avancar = 1'b1;
    @(negedge clock);
    avancar = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk_zero("abort");
    reset = 1'b0;
    repeat (15) @(negedge clock);
    chk_zero("post_abort");

    chk("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
